// File: rtl/cud_pkg.sv
// Shared types and constants for the capture unit: FSM state encoding,
// snapshot FIFO depth and timestamp width.
package cud_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ARMED = 1'b1
   } cud_state_e;

   localparam int FIFO_DEPTH = 2;
   localparam int TS_WIDTH   = 16;

endpackage

// File: rtl/cud_capture_if.sv
// Snapshot handshake bundle between the capture unit (master) and its
// consumer (slave).
interface cud_capture_if #(
   parameter int DW = 8
);
   logic [DW-1:0] snap_data;
   logic          snap_valid;
   logic          snap_ready;

   modport master (
      output snap_data,
      output snap_valid,
      input  snap_ready
   );

   modport slave (
      input  snap_data,
      input  snap_valid,
      output snap_ready
   );
endinterface

// File: rtl/cud_snap_fifo.sv
// Two-entry shift FIFO holding captured snapshots; slot 0 is always the head,
// so the head data and valid come straight from flops.
module cud_snap_fifo
   import cud_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          ready,
   output logic [DW-1:0] head_data,
   output logic          head_valid,
   output logic          can_push
);

   logic [DW-1:0]         slot_r [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] vld_r;
   logic                  pop_s;
   logic                  push_s;

   assign pop_s      = vld_r[0] & ready;
   assign can_push   = ~vld_r[1] | pop_s;
   assign push_s     = push & can_push;
   assign head_data  = slot_r[0];
   assign head_valid = vld_r[0];

   // Slot/valid update; a push into a full FIFO is only possible alongside a pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_r     <= '0;
         slot_r[0] <= '0;
         slot_r[1] <= '0;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (!vld_r[0]) begin
                  slot_r[0] <= push_data;
                  vld_r[0]  <= 1'b1;
               end else begin
                  slot_r[1] <= push_data;
                  vld_r[1]  <= 1'b1;
               end
            end
            2'b01: begin
               slot_r[0] <= slot_r[1];
               vld_r     <= {1'b0, vld_r[1]};
            end
            2'b11: begin
               if (vld_r[1]) begin
                  slot_r[0] <= slot_r[1];
                  slot_r[1] <= push_data;
               end else begin
                  slot_r[0] <= push_data;
               end
            end
            default: begin
               vld_r <= vld_r;
            end
         endcase
      end
   end

endmodule

// File: rtl/cud_capture.sv
// Up/down counter capture unit: extends the counter with a wrap count and
// snapshots {hi, cnt} into a 2-entry FIFO on trig. Optional macro
// CUD_CAPTURE_TIMESTAMP_EN prepends a free-running 16-bit timestamp.
module cud_capture
   import cud_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int HI_WIDTH = 4,
   parameter int ONE_SHOT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] cnt_in,
   input  logic             rollover_in,
   input  logic             ud_in,
   input  logic             load_en_in,
   input  logic             arm,
   input  logic             trig,
   input  logic             clr_ovf,
   cud_capture_if.master    snap,
   output logic             armed,
   output logic             ovf
);

`ifdef CUD_CAPTURE_TIMESTAMP_EN
   localparam int SNAP_W = TS_WIDTH + HI_WIDTH + WIDTH;
`else
   localparam int SNAP_W = HI_WIDTH + WIDTH;
`endif

   localparam logic [HI_WIDTH-1:0] HI_ONE = {{(HI_WIDTH-1){1'b0}}, 1'b1};

   logic [HI_WIDTH-1:0] hi_r;
   logic [HI_WIDTH-1:0] hi_adj_s;
   logic [SNAP_W-1:0]   ext_s;
   cud_state_e          state_r;
   cud_state_e          state_s;
   logic                ovf_r;
   logic                armed_s;
   logic                can_push_s;
   logic                accept_s;
   logic                lost_s;

   // Wrap-adjusted high word, so a wrap cycle already captures the new value.
   always_comb begin
      hi_adj_s = hi_r;
      if (rollover_in && ud_in) begin
         hi_adj_s = hi_r + HI_ONE;
      end else if (rollover_in) begin
         hi_adj_s = hi_r - HI_ONE;
      end else begin
         hi_adj_s = hi_r;
      end
   end

   // High-word register; a load clears it even on a coincident wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_r <= '0;
      end else if (load_en_in) begin
         hi_r <= '0;
      end else begin
         hi_r <= hi_adj_s;
      end
   end

`ifdef CUD_CAPTURE_TIMESTAMP_EN
   localparam logic [TS_WIDTH-1:0] TS_ONE = {{(TS_WIDTH-1){1'b0}}, 1'b1};
   logic [TS_WIDTH-1:0] ts_r;

   // Free-running timestamp sampled into the snapshot on the push cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         ts_r <= '0;
      end else begin
         ts_r <= ts_r + TS_ONE;
      end
   end

   assign ext_s = {ts_r, hi_adj_s, cnt_in};
`else
   assign ext_s = {hi_adj_s, cnt_in};
`endif

   assign armed_s  = (state_r == ARMED);
   assign accept_s = armed_s & trig & can_push_s;
   assign lost_s   = armed_s & trig & ~can_push_s;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FSM next state; arm while ARMED is a no-op, a lost capture never disarms.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (arm) begin
               state_s = ARMED;
            end else begin
               state_s = IDLE;
            end
         end
         ARMED: begin
            if (accept_s && (ONE_SHOT != 0)) begin
               state_s = IDLE;
            end else begin
               state_s = ARMED;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Sticky overflow flag; a new loss wins over a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_r <= 1'b0;
      end else if (lost_s) begin
         ovf_r <= 1'b1;
      end else if (clr_ovf) begin
         ovf_r <= 1'b0;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   cud_snap_fifo #(
      .DW (SNAP_W)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (accept_s),
      .push_data  (ext_s),
      .ready      (snap.snap_ready),
      .head_data  (snap.snap_data),
      .head_valid (snap.snap_valid),
      .can_push   (can_push_s)
   );

   assign armed = armed_s;
   assign ovf   = ovf_r;

endmodule

// File: tb/tb_cud_capture.sv
// Bench for cud_capture: a continuous-mode and a one-shot instance share one
// directed stimulus stream and are checked against a queue-level model.
module tb_cud_capture;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] cnt;
   logic       rollover, ud, load_en, arm, trig, clr_ovf, ready;
   logic       armed0, ovf0, armed1, ovf1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cud_capture_if #(.DW(8)) snap0 ();
   cud_capture_if #(.DW(8)) snap1 ();
   assign snap0.snap_ready = ready;
   assign snap1.snap_ready = ready;

   cud_capture #(.WIDTH(4), .HI_WIDTH(4), .ONE_SHOT(0)) dut0 (
      .clk(clk), .rst(rst), .cnt_in(cnt), .rollover_in(rollover), .ud_in(ud),
      .load_en_in(load_en), .arm(arm), .trig(trig), .clr_ovf(clr_ovf),
      .snap(snap0.master), .armed(armed0), .ovf(ovf0)
   );

   cud_capture #(.WIDTH(4), .HI_WIDTH(4), .ONE_SHOT(1)) dut1 (
      .clk(clk), .rst(rst), .cnt_in(cnt), .rollover_in(rollover), .ud_in(ud),
      .load_en_in(load_en), .arm(arm), .trig(trig), .clr_ovf(clr_ovf),
      .snap(snap1.master), .armed(armed1), .ovf(ovf1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: wrap counter, snapshot list (count + entries), armed bit, ovf bit.
   logic [3:0] m_hi    [2];
   logic [7:0] m_q     [2][2];
   int         m_n     [2];
   bit         m_armed [2];
   bit         m_ovf   [2];
   bit         m_live = 1'b0;

   task automatic model_step(input int k, input bit one_shot);
      logic [3:0] hadj;
      logic [7:0] ext;
      bit pop, take, lost;
      if (rst) begin
         m_hi[k] = 4'd0; m_n[k] = 0; m_armed[k] = 1'b0; m_ovf[k] = 1'b0;
      end else begin
         hadj = m_hi[k];
         if (rollover) hadj = ud ? m_hi[k] + 4'd1 : m_hi[k] - 4'd1;
         ext  = {hadj, cnt};
         pop  = (m_n[k] > 0) && ready;
         take = m_armed[k] && trig && ((m_n[k] - (pop ? 1 : 0)) < 2);
         lost = m_armed[k] && trig && !take;
         if (pop) begin
            m_q[k][0] = m_q[k][1];
            m_n[k] = m_n[k] - 1;
         end
         if (take) begin
            m_q[k][m_n[k]] = ext;
            m_n[k] = m_n[k] + 1;
         end
         if (lost) m_ovf[k] = 1'b1;
         else if (clr_ovf) m_ovf[k] = 1'b0;
         if (m_armed[k]) begin
            if (take && one_shot) m_armed[k] = 1'b0;
         end else begin
            m_armed[k] = arm;
         end
         m_hi[k] = load_en ? 4'd0 : hadj;
      end
   endtask

   always @(posedge clk) begin
      model_step(0, 1'b0);
      model_step(1, 1'b1);
      if (rst) m_live = 1'b1;
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin : compare
      logic       v, a, o;
      logic [7:0] d;
      if (m_live) begin
         for (int k = 0; k < 2; k++) begin
            v = (k == 0) ? snap0.snap_valid : snap1.snap_valid;
            d = (k == 0) ? snap0.snap_data  : snap1.snap_data;
            a = (k == 0) ? armed0 : armed1;
            o = (k == 0) ? ovf0   : ovf1;
            check($sformatf("model_valid%0d", k), v, m_n[k] > 0);
            check($sformatf("model_armed%0d", k), a, m_armed[k]);
            check($sformatf("model_ovf%0d", k), o, m_ovf[k]);
            if (m_n[k] > 0) check($sformatf("model_data%0d", k), d, m_q[k][0]);
         end
      end
   end

   // One cycle of stimulus: cnt, rollover, ud, load, arm, trig, clr_ovf, ready.
   task automatic step(input logic [3:0] c, input bit ro, input bit u, input bit ld,
                       input bit ar, input bit tr, input bit cl, input bit rd);
      cnt = c; rollover = ro; ud = u; load_en = ld;
      arm = ar; trig = tr; clr_ovf = cl; ready = rd;
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      step(4'd0, 0, 0, 0, 0, 0, 0, 0);
      step(4'd0, 0, 0, 0, 0, 0, 0, 0);
      check("rst_valid", snap0.snap_valid, 1'b0);
      check("rst_data", snap0.snap_data, 8'h00);
      check("rst_armed", armed0, 1'b0);
      check("rst_ovf", ovf0, 1'b0);
      rst = 1'b0;

      step(4'd0, 0, 0, 0, 1, 0, 0, 0);
      check("arm0", armed0, 1'b1);
      check("arm1", armed1, 1'b1);

      // Up wrap captured on the wrap cycle.
      step(4'd15, 0, 1, 0, 0, 0, 0, 0);
      step(4'd0, 1, 1, 0, 0, 1, 0, 0);
      check("up_wrap_valid", snap0.snap_valid, 1'b1);
      check("up_wrap_data", snap0.snap_data, 8'h10);
      check("oneshot_data", snap1.snap_data, 8'h10);
      check("oneshot_disarm", armed1, 1'b0);
      step(4'd0, 0, 0, 0, 0, 0, 0, 1);

      // Down wrap from hi=0.
      step(4'd0, 0, 0, 1, 0, 0, 0, 0);
      step(4'd15, 1, 0, 0, 0, 1, 0, 0);
      check("down_wrap_data", snap0.snap_data, 8'hFF);
      check("idle_trig_valid", snap1.snap_valid, 1'b0);
      check("idle_trig_ovf", ovf1, 1'b0);
      step(4'd15, 0, 0, 0, 0, 0, 0, 1);

      // Load beats a coincident wrap: hi 3 -> 0, not 4.
      step(4'd0, 0, 0, 1, 0, 0, 0, 0);
      step(4'd0, 1, 1, 0, 0, 0, 0, 0);
      step(4'd0, 1, 1, 0, 0, 0, 0, 0);
      step(4'd0, 1, 1, 0, 0, 0, 0, 0);
      step(4'd0, 1, 1, 1, 0, 0, 0, 0);
      step(4'd5, 0, 0, 0, 0, 1, 0, 0);
      check("load_prec_data", snap0.snap_data, 8'h05);
      step(4'd5, 0, 0, 0, 0, 0, 0, 1);

      // Overflow with the consumer stalled; one-shot takes only the first.
      step(4'd0, 0, 0, 0, 1, 0, 0, 0);
      step(4'd1, 0, 0, 0, 0, 1, 0, 0);
      step(4'd2, 0, 0, 0, 0, 1, 0, 0);
      step(4'd3, 0, 0, 0, 0, 1, 0, 0);
      check("ovf_head", snap0.snap_data, 8'h01);
      check("ovf_set", ovf0, 1'b1);
      check("oneshot_ovf", ovf1, 1'b0);
      check("oneshot_armed", armed1, 1'b0);
      step(4'd3, 0, 0, 0, 0, 1, 1, 0);
      check("ovf_set_beats_clr", ovf0, 1'b1);
      step(4'd3, 0, 0, 0, 0, 0, 1, 0);
      check("ovf_clr", ovf0, 1'b0);
      step(4'd3, 0, 0, 0, 0, 0, 0, 1);
      check("second_entry", snap0.snap_data, 8'h02);
      step(4'd3, 0, 0, 0, 0, 0, 0, 1);

      // Full FIFO with pop and push together stays full, no overflow.
      step(4'd6, 0, 0, 0, 0, 1, 0, 0);
      step(4'd7, 0, 0, 0, 0, 1, 0, 0);
      step(4'd8, 0, 0, 0, 0, 1, 0, 1);
      step(4'd9, 0, 0, 0, 0, 1, 0, 1);
      step(4'd10, 0, 0, 0, 0, 1, 0, 1);
      check("stream_ovf", ovf0, 1'b0);
      check("stream_head", snap0.snap_data, 8'h09);
      step(4'd0, 0, 0, 0, 0, 0, 0, 1);
      step(4'd0, 0, 0, 0, 0, 0, 0, 1);

      // Reset mid-operation overrides arm/trig and discards entries.
      step(4'd1, 0, 0, 0, 0, 1, 0, 0);
      step(4'd2, 0, 0, 0, 0, 1, 0, 0);
      step(4'd3, 0, 0, 0, 0, 1, 0, 0);
      check("pre_rst_ovf", ovf0, 1'b1);
      rst = 1'b1;
      step(4'd4, 1, 1, 0, 1, 1, 0, 1);
      check("mid_rst_valid", snap0.snap_valid, 1'b0);
      check("mid_rst_armed", armed0, 1'b0);
      check("mid_rst_ovf", ovf0, 1'b0);
      check("mid_rst_data", snap0.snap_data, 8'h00);
      rst = 1'b0;
      step(4'd0, 0, 0, 0, 0, 0, 0, 0);
      step(4'd0, 0, 0, 0, 0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
